// File: rtl/padding_stream.sv
// padding_stream
//   Surrounds a raster-order feature map with a border of pad pixels. The input map
//   is SIZE_H x SIZE_W pixels, each CHANNEL lanes of N bits. The output map is
//   (PAD_T+SIZE_H+PAD_B) x (PAD_L+SIZE_W+PAD_R) pixels. Both sides use valid/ready
//   handshakes. The output is registered, so a beat appears one cycle after it is
//   accepted.
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   ce         enable; low aborts the current frame on the next edge
//   pad_value  pad pixel value, captured when pixel (0,0) of each frame is issued
//   din        input pixel
//   din_vld    input pixel valid
//   din_rdy    input accepted this cycle (combinational, independent of din_vld)
//   dout       output pixel (registered)
//   dout_vld   output pixel valid
//   dout_rdy   downstream accepts dout
//   dout_eol   dout is the last pixel of an output row
//   dout_last  dout is the last pixel of the frame
//   busy       a frame has been started and its last beat has not yet transferred
module padding_stream #(
    parameter int N       = 8,
    parameter int CHANNEL = 3,
    parameter int SIZE_H  = 32,
    parameter int SIZE_W  = 32,
    parameter int PAD_T   = 1,
    parameter int PAD_B   = 1,
    parameter int PAD_L   = 1,
    parameter int PAD_R   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic [CHANNEL*N-1:0]   pad_value,
    input  logic [CHANNEL*N-1:0]   din,
    input  logic                   din_vld,
    output logic                   din_rdy,
    output logic [CHANNEL*N-1:0]   dout,
    output logic                   dout_vld,
    input  logic                   dout_rdy,
    output logic                   dout_eol,
    output logic                   dout_last,
    output logic                   busy
);

    localparam int W     = CHANNEL * N;
    localparam int OUT_H = SIZE_H + PAD_T + PAD_B;
    localparam int OUT_W = SIZE_W + PAD_L + PAD_R;
    localparam int RW    = $clog2(OUT_H + 1);
    localparam int CW    = $clog2(OUT_W + 1);

    localparam logic [RW-1:0] ROW_LO   = RW'(PAD_T);
    localparam logic [RW-1:0] ROW_SPAN = RW'(SIZE_H);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);
    localparam logic [CW-1:0] COL_LO   = CW'(PAD_L);
    localparam logic [CW-1:0] COL_SPAN = CW'(SIZE_W);
    localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);

    logic [RW-1:0] row, row_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [W-1:0]  pad_reg, pad_cur;
    logic [RW-1:0] row_off;
    logic [CW-1:0] col_off;
    logic          load, interior, issue;
    logic          at_first, at_eol, at_last;

    // Interior test as a single unsigned compare: rows above the map wrap the
    // offset to at least 2^RW - PAD_T, which always exceeds SIZE_H because the
    // counter width covers OUT_H.
    assign row_off  = row - ROW_LO;
    assign col_off  = col - COL_LO;
    assign interior = (row_off < ROW_SPAN) && (col_off < COL_SPAN);

    assign load     = ~dout_vld | dout_rdy;
    assign din_rdy  = ce & load & interior;
    assign issue    = ce & load & (~interior | din_vld);

    assign at_first = (row == '0) && (col == '0);
    assign at_eol   = (col == COL_LAST);
    assign at_last  = at_eol && (row == ROW_LAST);

    // Pixel (0,0) takes the live pad_value so a new frame picks up the new value
    // on its very first beat; the rest of the frame uses the captured copy.
    assign pad_cur  = at_first ? pad_value : pad_reg;

    always_comb begin
        row_nxt = row;
        col_nxt = col;
        if (at_eol) begin
            col_nxt = '0;
            row_nxt = at_last ? '0 : row + 1'b1;
        end else begin
            col_nxt = col + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row       <= '0;
            col       <= '0;
            pad_reg   <= '0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            dout_eol  <= 1'b0;
            dout_last <= 1'b0;
            busy      <= 1'b0;
        end else if (!ce) begin
            row       <= '0;
            col       <= '0;
            dout_vld  <= 1'b0;
            dout_eol  <= 1'b0;
            dout_last <= 1'b0;
            busy      <= 1'b0;
        end else if (load) begin
            if (issue) begin
                dout      <= interior ? din : pad_cur;
                dout_vld  <= 1'b1;
                dout_eol  <= at_eol;
                dout_last <= at_last;
                row       <= row_nxt;
                col       <= col_nxt;
                if (at_first) begin
                    pad_reg <= pad_value;
                end
            end else begin
                dout_vld <= 1'b0;
            end
            // Starting a new frame wins over finishing the old one, so busy
            // stays high across back-to-back frames.
            if (issue && at_first) begin
                busy <= 1'b1;
            end else if (dout_vld && dout_rdy && dout_last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_padding_stream.sv
module tb_padding_stream;

    localparam int N  = 8;
    localparam int CH = 3;
    localparam int W  = N * CH;

    typedef logic [W-1:0] pix_t;
    typedef struct packed {
        pix_t data;
        logic eol;
        logic last;
    } beat_t;
    typedef pix_t pix_q_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // DUT A: 4x4 map, one pad on every side
    logic ce, din_vld, dout_rdy, din_rdy, dout_vld, dout_eol, dout_last, busy;
    pix_t pad_value, din, dout;

    // DUT B: 3x3 map, PAD_T=0 PAD_B=2 PAD_L=2 PAD_R=0
    logic b_ce, b_din_vld, b_dout_rdy, b_din_rdy, b_dout_vld, b_dout_eol, b_dout_last, b_busy;
    pix_t b_pad_value, b_din, b_dout;

    padding_stream #(.N(N), .CHANNEL(CH), .SIZE_H(4), .SIZE_W(4),
                     .PAD_T(1), .PAD_B(1), .PAD_L(1), .PAD_R(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pad_value(pad_value),
        .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
        .dout_eol(dout_eol), .dout_last(dout_last), .busy(busy));

    padding_stream #(.N(N), .CHANNEL(CH), .SIZE_H(3), .SIZE_W(3),
                     .PAD_T(0), .PAD_B(2), .PAD_L(2), .PAD_R(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ce(b_ce), .pad_value(b_pad_value),
        .din(b_din), .din_vld(b_din_vld), .din_rdy(b_din_rdy),
        .dout(b_dout), .dout_vld(b_dout_vld), .dout_rdy(b_dout_rdy),
        .dout_eol(b_dout_eol), .dout_last(b_dout_last), .busy(b_busy));

    int    vectors = 0;
    int    miscompares = 0;
    int    beats_a = 0;
    int    beats_b = 0;
    beat_t exp_a[$];
    beat_t exp_b[$];
    pix_q_t src;
    pix_q_t src_b;
    bit    in_xfer;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: walk the padded raster, taking input pixels in order for the
    // interior and the pad value everywhere else.
    task automatic push_model(input int which, input int sh, input int sw,
                              input int pt, input int pb, input int pl, input int pr,
                              input pix_t pad, input pix_q_t pix, input int off);
        int    oh = sh + pt + pb;
        int    ow = sw + pl + pr;
        int    k  = off;
        beat_t b;
        for (int r = 0; r < oh; r++) begin
            for (int c = 0; c < ow; c++) begin
                if (r >= pt && r < pt + sh && c >= pl && c < pl + sw) begin
                    b.data = pix[k];
                    k++;
                end else begin
                    b.data = pad;
                end
                b.eol  = (c == ow - 1);
                b.last = (r == oh - 1) && (c == ow - 1);
                if (which == 0) exp_a.push_back(b);
                else            exp_b.push_back(b);
            end
        end
    endtask

    // Monitor A: pops the scoreboard on every transfer and checks that a
    // stalled beat is held unchanged across the following edge.
    pix_t p_dout;
    logic p_eol, p_last;
    bit   p_stall = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall)
                check("stall_hold", {5'd0, dout_vld, dout_eol, dout_last, dout},
                      {5'd0, 1'b1, p_eol, p_last, p_dout});
            if (ce && dout_vld && dout_rdy) begin
                beats_a++;
                if (exp_a.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat_a: unexpected beat %h, expected none", dout);
                end else begin
                    e = exp_a.pop_front();
                    check($sformatf("beat_a[%0d]", beats_a), {6'd0, dout_eol, dout_last, dout},
                          {6'd0, e.eol, e.last, e.data});
                end
            end
            p_stall = ce && dout_vld && !dout_rdy;
            p_dout  = dout;
            p_eol   = dout_eol;
            p_last  = dout_last;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && b_ce && b_dout_vld && b_dout_rdy) begin
            beats_b++;
            if (exp_b.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL beat_b: unexpected beat %h, expected none", b_dout);
            end else begin
                e = exp_b.pop_front();
                check($sformatf("beat_b[%0d]", beats_b), {6'd0, b_dout_eol, b_dout_last, b_dout},
                      {6'd0, e.eol, e.last, e.data});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        in_xfer = din_vld && din_rdy;
        @(posedge clk);
        #1;
    endtask

    // Streams src into DUT A until n_beats output transfers are seen, then
    // stalls the output and parks the block with ce=0.
    task automatic run_stream(input int n_beats, input bit rnd_rdy, input int gap_len,
                              input int abort_at, input int pad_switch_at,
                              input pix_t pad_new, input bit chk_busy);
        int base = beats_a;
        int si = 0;
        int gap = 0;
        int budget = 0;
        bit aborted = 1'b0;
        ce       = 1'b1;
        dout_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        din_vld  = (src.size() > 0);
        din      = src[0];
        while (beats_a - base < n_beats && budget < 3000) begin
            tick();
            budget++;
            if (in_xfer) begin
                si++;
                gap = gap_len;
            end else if (gap > 0) begin
                gap--;
            end
            if (abort_at > 0 && !aborted && beats_a - base == abort_at) begin
                aborted  = 1'b1;
                ce       = 1'b0;
                dout_rdy = 1'b0;
                exp_a.delete();
                #1;
                check("abort_din_rdy", din_rdy, 0);
                tick();
                check("abort_dout_vld", dout_vld, 0);
                check("abort_busy", busy, 0);
                ce   = 1'b1;
                si   = 0;
                gap  = 0;
                base = beats_a;
                push_model(0, 4, 4, 1, 1, 1, 1, pad_value, src, 0);
            end
            if (pad_switch_at > 0 && beats_a - base >= pad_switch_at) pad_value = pad_new;
            if (chk_busy && beats_a - base >= 1 && beats_a - base < n_beats)
                check("busy_in_frame", busy, 1);
            dout_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            din_vld  = (si < src.size()) && (gap == 0);
            din      = (si < src.size()) ? src[si] : '0;
        end
        check("beat_count", beats_a - base, n_beats);
        dout_rdy = 1'b0;
        din_vld  = 1'b0;
        tick();
        check("queue_drained", exp_a.size(), 0);
        ce = 1'b0;
        tick();
    endtask

    task automatic load_counting(input int count);
        src.delete();
        for (int i = 1; i <= count; i++) src.push_back(pix_t'(((i - 1) % 16) + 1 + 16 * ((i - 1) / 16) * 16));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        int budget;
        bit bx;
        int bi;

        rst_n = 1'b0;
        ce = 1'b1; dout_rdy = 1'b1; din_vld = 1'b1; din = pix_t'(24'h123456);
        pad_value = pix_t'(24'h777777);
        b_ce = 1'b0; b_dout_rdy = 1'b0; b_din_vld = 1'b0; b_din = '0; b_pad_value = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_dout_eol", dout_eol, 0);
        check("rst_dout_last", dout_last, 0);
        check("rst_busy", busy, 0);
        ce = 1'b0; dout_rdy = 1'b0; din_vld = 1'b0;
        rst_n = 1'b1;
        tick();

        // Test 1: 1..16, pad 0, output always ready
        pad_value = '0;
        load_counting(16);
        push_model(0, 4, 4, 1, 1, 1, 1, pad_value, src, 0);
        run_stream(36, 1'b0, 0, 0, 0, '0, 1'b0);

        // Test 3: random data and pad, output ready toggling randomly
        pad_value = pix_t'($urandom());
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back(pix_t'($urandom()));
        push_model(0, 4, 4, 1, 1, 1, 1, pad_value, src, 0);
        run_stream(36, 1'b1, 0, 0, 0, '0, 1'b0);

        // Test 4: 3-cycle gaps between input pixels
        pad_value = '0;
        load_counting(16);
        push_model(0, 4, 4, 1, 1, 1, 1, pad_value, src, 0);
        run_stream(36, 1'b0, 3, 0, 0, '0, 1'b0);

        // Gaps and random output ready together
        pad_value = pix_t'($urandom());
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back(pix_t'($urandom()));
        push_model(0, 4, 4, 1, 1, 1, 1, pad_value, src, 0);
        run_stream(36, 1'b1, 3, 0, 0, '0, 1'b0);

        // Test 5: abort after beat 10, then a fresh full frame
        pad_value = '0;
        load_counting(16);
        push_model(0, 4, 4, 1, 1, 1, 1, pad_value, src, 0);
        run_stream(36, 1'b0, 0, 10, 0, '0, 1'b0);

        // Test 6: two back-to-back frames, pad 0 -> 0x55 during frame 1
        pad_value = '0;
        src.delete();
        for (int i = 1; i <= 32; i++) src.push_back(pix_t'(i));
        push_model(0, 4, 4, 1, 1, 1, 1, pix_t'(0), src, 0);
        push_model(0, 4, 4, 1, 1, 1, 1, {3{8'h55}}, src, 16);
        run_stream(72, 1'b0, 0, 0, 20, {3{8'h55}}, 1'b1);

        // Test 2: asymmetric pads on DUT B
        src_b.delete();
        for (int i = 1; i <= 9; i++) src_b.push_back({3{8'(i)}});
        push_model(1, 3, 3, 0, 2, 2, 0, {3{8'hAA}}, src_b, 0);
        b_pad_value = {3{8'hAA}};
        b_ce = 1'b1; b_dout_rdy = 1'b1; b_din_vld = 1'b1; b_din = src_b[0];
        bi = 0;
        budget = 0;
        while (beats_b < 25 && budget < 500) begin
            @(negedge clk);
            bx = b_din_vld && b_din_rdy;
            @(posedge clk);
            #1;
            budget++;
            if (bx) bi++;
            b_din_vld = (bi < 9);
            b_din     = (bi < 9) ? src_b[bi] : '0;
        end
        b_dout_rdy = 1'b0;
        b_din_vld  = 1'b0;
        check("beat_count_b", beats_b, 25);
        @(posedge clk);
        #1;
        check("queue_drained_b", exp_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
